// File: rtl/util_sync_filter_pkg.sv
// Shared helpers for the synchronizer/filter slice: the per-channel filter state
// type, clog2, and the parameter legality predicates used at elaboration.
package util_sync_filter_pkg;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } filt_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // The counter must hold F-1, so F=1 and F=2 both need a single bit.
  function automatic int cnt_width(input int f);
    return (clog2(f) < 1) ? 1 : clog2(f);
  endfunction

  function automatic bit stages_ok(input int s);
    return (s >= 2) && (s <= 4);
  endfunction

  function automatic bit filter_ok(input int f);
    return (f >= 0) && (f <= 65535);
  endfunction

endpackage

// File: rtl/util_sync_filter_if.sv
// Level-signal bundle for util_sync_filter. The inputs are asynchronous levels
// with no handshake; pending_o exposes each channel's filter state.
interface util_sync_filter_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] data_i;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] rise_o;
  logic [WIDTH-1:0] fall_o;
  logic [WIDTH-1:0] pending_o;

  modport master (output data_i, input data_o, rise_o, fall_o, pending_o);
  modport slave  (input data_i, output data_o, rise_o, fall_o, pending_o);
endinterface

// File: rtl/util_sync_filter_ch.sv
// One channel: STAGES-deep synchronizer chain, optional stability filter
// (STABLE/PENDING), and registered rise/fall pulses aligned with o_data.
module util_sync_filter_ch
  import util_sync_filter_pkg::*;
#(
  parameter int   STAGES        = 2,
  parameter int   FILTER_CYCLES = 0,
  parameter logic RST_BIT       = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_data,
  output logic o_data,
  output logic o_rise,
  output logic o_fall,
  output logic o_pending
);

`ifdef XILINX_FPGA
  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic [STAGES-1:0] r_sync;
`else
  logic [STAGES-1:0] r_sync;
`endif
  logic w_sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= {STAGES{RST_BIT}};
    else          r_sync <= {r_sync[STAGES-2:0], i_data};
  end

  assign w_sync_q = r_sync[STAGES-1];

  if (FILTER_CYCLES == 0) begin : g_bypass
    logic r_rise;
    logic r_fall;

    // The last chain flop is the output; its input is the next output value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
      end else begin
        r_rise <= r_sync[STAGES-2] & ~r_sync[STAGES-1];
        r_fall <= ~r_sync[STAGES-2] & r_sync[STAGES-1];
      end
    end

    assign o_data    = w_sync_q;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_pending = 1'b0;
  end else begin : g_filter
    localparam int CW = cnt_width(FILTER_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    filt_state_e     r_state;
    filt_state_e     w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_data;
    logic            w_data_nxt;
    logic            r_rise;
    logic            r_fall;
    logic            w_diff;

    assign w_diff = (w_sync_q != r_data);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_data  <= RST_BIT;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_data  <= w_data_nxt;
        r_rise  <= w_data_nxt & ~r_data;
        r_fall  <= ~w_data_nxt & r_data;
      end
    end

    // Commit happens on the edge where the mismatch has already been seen F-1 times.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_data_nxt  = r_data;
      case (r_state)
        ST_STABLE: begin
          if (w_diff) begin
            if (r_cnt == CNT_LAST) begin
              w_data_nxt = w_sync_q;
              w_cnt_nxt  = '0;
            end else begin
              w_state_nxt = ST_PENDING;
              w_cnt_nxt   = r_cnt + 1'b1;
            end
          end
        end
        ST_PENDING: begin
          if (!w_diff) begin
            w_state_nxt = ST_STABLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_STABLE;
            w_data_nxt  = w_sync_q;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      o_data    = r_data;
      o_rise    = r_rise;
      o_fall    = r_fall;
      o_pending = (r_state == ST_PENDING);
    end
  end

endmodule

// File: rtl/util_sync_filter.sv
// Multi-channel level synchronizer with optional glitch filter and edge pulses.
// Channels are independent; each is one util_sync_filter_ch instance.
module util_sync_filter
  import util_sync_filter_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b0}},
  parameter int               FILTER_CYCLES = 0
) (
  input logic               clk_i,
  input logic               reset_n_i,
  util_sync_filter_if.slave bus
);

  if (!stages_ok(STAGES)) begin : g_bad_stages
    $error("util_sync_filter: STAGES must be in 2..4");
  end
  if (!filter_ok(FILTER_CYCLES)) begin : g_bad_filter
    $error("util_sync_filter: FILTER_CYCLES must be in 0..65535");
  end

  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_pending;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ch
    util_sync_filter_ch #(
      .STAGES        (STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .RST_BIT       (RESET_VAL[gi])
    ) u_ch (
      .i_clk     (clk_i),
      .i_rst_n   (reset_n_i),
      .i_data    (bus.data_i[gi]),
      .o_data    (w_data[gi]),
      .o_rise    (w_rise[gi]),
      .o_fall    (w_fall[gi]),
      .o_pending (w_pending[gi])
    );
  end

  assign bus.data_o    = w_data;
  assign bus.rise_o    = w_rise;
  assign bus.fall_o    = w_fall;
  assign bus.pending_o = w_pending;

endmodule

// File: tb/tb_util_sync_filter.sv
// Directed bench: WIDTH=4/STAGES=3/F=4 filter instance driven from a vector
// table plus reset corner sequences, and an F=0/STAGES=2 instance on random data.
module tb_util_sync_filter;
  localparam int W = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] o;
    logic [W-1:0] r;
    logic [W-1:0] f;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vecs[$];
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  util_sync_filter_if #(.WIDTH(W)) bus_a ();
  util_sync_filter_if #(.WIDTH(W)) bus_b ();

  util_sync_filter #(
    .WIDTH(W), .STAGES(3), .RESET_VAL(4'h0), .FILTER_CYCLES(4)
  ) dut_a (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus_a)
  );

  util_sync_filter #(
    .WIDTH(W), .STAGES(2), .RESET_VAL(4'h0), .FILTER_CYCLES(0)
  ) dut_b (
    .clk_i(clk), .reset_n_i(rst_n), .bus(bus_b)
  );

  function automatic void add(input logic [W-1:0] d, o, r, f);
    vec_t v;
    v.d = d; v.o = o; v.r = r; v.f = f;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic [W-1:0] d, o, r, f);
    for (int k = 0; k < n; k++) add(d, o, r, f);
  endfunction

  task automatic check(input string name, input logic [W-1:0] ao, ar, af,
                       input logic [W-1:0] eo, er, ef);
    n_tests++;
    if (ao !== eo || ar !== er || af !== ef) begin
      n_fail++;
      $display("FAIL %s: data_o/rise_o/fall_o got %h/%h/%h expected %h/%h/%h",
               name, ao, ar, af, eo, er, ef);
    end
  endtask

  task automatic step_a(input logic [W-1:0] d);
    bus_a.data_i = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] e;
    logic [W-1:0] e_prev;

    // Release with 4'hF held: output stays 0 for 6 edges, commits at edge 7.
    add_n(6, 4'hF, 4'h0, 4'h0, 4'h0);
    add  (   4'hF, 4'hF, 4'hF, 4'h0);
    add  (   4'hF, 4'hF, 4'h0, 4'h0);
    // All channels fall back to 0.
    add_n(6, 4'h0, 4'hF, 4'h0, 4'h0);
    add  (   4'h0, 4'h0, 4'h0, 4'hF);
    add_n(3, 4'h0, 4'h0, 4'h0, 4'h0);
    // Three-cycle glitch on bit 0 is rejected.
    add_n(3, 4'h1, 4'h0, 4'h0, 4'h0);
    add_n(10, 4'h0, 4'h0, 4'h0, 4'h0);
    // Exactly four cycles on bit 0 passes as a four-cycle output pulse.
    add_n(4, 4'h1, 4'h0, 4'h0, 4'h0);
    add_n(2, 4'h0, 4'h0, 4'h0, 4'h0);
    add  (   4'h0, 4'h1, 4'h1, 4'h0);
    add_n(3, 4'h0, 4'h1, 4'h0, 4'h0);
    add  (   4'h0, 4'h0, 4'h0, 4'h1);
    add_n(3, 4'h0, 4'h0, 4'h0, 4'h0);
    // Settle 4'h4, then swap bits 1 and 2 in the same cycle.
    add_n(6, 4'h4, 4'h0, 4'h0, 4'h0);
    add  (   4'h4, 4'h4, 4'h4, 4'h0);
    add_n(3, 4'h4, 4'h4, 4'h0, 4'h0);
    add_n(6, 4'h2, 4'h4, 4'h0, 4'h0);
    add  (   4'h2, 4'h2, 4'h2, 4'h4);
    add_n(2, 4'h2, 4'h2, 4'h0, 4'h0);

    rst_n = 1'b0;
    bus_a.data_i = 4'hF;
    bus_b.data_i = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", bus_a.data_o, bus_a.rise_o, bus_a.fall_o, 4'h0, 4'h0, 4'h0);
    check("reset_b", bus_b.data_o, bus_b.rise_o, bus_b.fall_o, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step_a(vecs[i].d);
      check($sformatf("vec%0d", i), bus_a.data_o, bus_a.rise_o, bus_a.fall_o,
            vecs[i].o, vecs[i].r, vecs[i].f);
    end

    // Reset lands two cycles into a pending 4'h2 -> 4'hD change.
    for (int k = 0; k < 5; k++) begin
      step_a(4'hD);
      check($sformatf("pend%0d", k), bus_a.data_o, bus_a.rise_o, bus_a.fall_o,
            4'h2, 4'h0, 4'h0);
    end
    #1 rst_n = 1'b0;
    #1;
    check("rst_immediate", bus_a.data_o, bus_a.rise_o, bus_a.fall_o, 4'h0, 4'h0, 4'h0);
    bus_a.data_i = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step_a(4'h0);
      check($sformatf("post_rst%0d", k), bus_a.data_o, bus_a.rise_o, bus_a.fall_o,
            4'h0, 4'h0, 4'h0);
    end

    // Bypass instance: output is the input two edges later, with edge pulses.
    exp_q.push_back(bus_b.data_i);
    e_prev = 4'h0;
    for (int k = 0; k < 40; k++) begin
      d = 4'($urandom_range(0, 15));
      bus_b.data_i = d;
      exp_q.push_back(d);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check($sformatf("bypass%0d", k), bus_b.data_o, bus_b.rise_o, bus_b.fall_o,
            e, e & ~e_prev, ~e & e_prev);
      e_prev = e;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/util_sync_filter.md
UTIL_SYNC_FILTER -- requirements
Module: util_sync_filter

Interface
REQ-001 Parameter WIDTH, default 1: number of independent single-bit channels.
REQ-002 Parameter STAGES, default 2: synchronizer flop depth per channel; legal range 2..4.
REQ-003 Parameter RESET_VAL, default {WIDTH{1'b0}}: reset value of chain, data_o and filter state, per bit.
REQ-004 Parameter FILTER_CYCLES, default 0: consecutive stable cycles required before data_o follows; 0 = filter bypassed; legal range 0..65535.
REQ-005 clk_i  input  1  sole clock; all state on rising edge.
REQ-006 reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 data_i  input  WIDTH  asynchronous level inputs.
REQ-008 data_o  output  WIDTH  synchronized, filtered levels (registered).
REQ-009 rise_o  output  WIDTH  one-cycle pulse per channel on data_o 0->1 (registered).
REQ-010 fall_o  output  WIDTH  one-cycle pulse per channel on data_o 1->0 (registered).

Function
REQ-011 Each channel SHALL pass data_i through a STAGES-deep flop chain; the last stage is sync_q.
REQ-012 FILTER_CYCLES=0: data_o SHALL equal sync_q; latency STAGES cycles; at STAGES=2, behaviour is identical to the existing 2-flop synchronizer.
REQ-013 FILTER_CYCLES=F>0: per-channel counter SHALL increment each cycle sync_q != data_o and clear each cycle sync_q == data_o.
REQ-014 When sync_q != data_o and counter == F-1, data_o SHALL take sync_q on that edge and the counter SHALL clear; total latency STAGES+F cycles.
REQ-015 Input excursions holding sync_q for fewer than F cycles SHALL leave data_o, rise_o, fall_o unchanged.
REQ-016 Counter width SHALL be the minimum bits to hold F-1 (at least 1); counter SHALL never wrap.
REQ-017 rise_o[i] SHALL be 1 exactly in the first cycle data_o[i] is 1 after being 0; fall_o[i] likewise for 1->0; never both set.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several bits SHALL each produce their own pulses in the same cycle.
REQ-019 Per channel, the filter SHALL be a two-state machine STABLE (counter 0) / PENDING (counter >0); PENDING -> STABLE on match or on commit.

Reset
REQ-020 reset_n_i low SHALL immediately force chain flops and data_o to RESET_VAL, counters to 0, rise_o/fall_o to 0.
REQ-021 Reset asserted mid-count SHALL discard pending transitions; no pulse SHALL be emitted for the discarded change.
REQ-022 After release with data_i != RESET_VAL, data_o SHALL reach data_i after STAGES+F cycles with the matching edge pulse.

Structure
REQ-023 A shared util package SHALL hold the clog2 function and the parameter legality checks (elaboration error on illegal STAGES/FILTER_CYCLES).
REQ-024 Per-channel logic SHALL be one sub-module, util_sync_filter_ch, instantiated WIDTH times via generate.
REQ-025 The chain flops SHALL carry the FPGA async-register/keep attributes under XILINX_FPGA, plain flops otherwise.

Verification (WIDTH=4, STAGES=3, F=4, RESET_VAL=4'h0 unless stated)
REQ-026 data_i=4'hF during reset, release -> data_o=4'h0 for 6 cycles, 4'hF at edge 7, rise_o=4'hF for exactly that cycle.
REQ-027 data_i[0] high 3 cycles then low -> data_o, rise_o, fall_o stay 0.
REQ-028 data_i[0] high exactly 4 cycles -> data_o[0] high 4 cycles starting edge 7; rise_o[0], fall_o[0] one pulse each.
REQ-029 Same cycle data_i[1] 0->1 and data_i[2] 1->0 (from settled 4'h4) -> rise_o=4'h2 and fall_o=4'h4 in the same cycle, 7 edges later.
REQ-030 Reset asserted 2 cycles into a pending transition -> outputs 4'h0 immediately, no pulse after release unless input persists per REQ-022.
REQ-031 F=0, STAGES=2: random data_i -> data_o equals data_i delayed exactly 2 cycles.
